// File: rtl/fp_accel_pkg.sv
// Shared definitions for the floating-point accelerator: word width, sequencer state codes, zero constant.
package fp_accel_pkg;

  function automatic int dataWidth(input int fracWidth, input int expWidth);
    return fracWidth + expWidth;
  endfunction

  typedef logic [1:0] seqState_t;

  localparam seqState_t IDLE  = 2'd0;
  localparam seqState_t ISSUE = 2'd1;
  localparam seqState_t WAIT  = 2'd2;
  localparam seqState_t RESP  = 2'd3;

  localparam int FP_ZERO = 0;

endpackage

// File: rtl/fp_accum_sequencer_if.sv
// Command, operand RAM, accumulator and response signals of the accumulator sequencer.
interface fp_accum_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  cmdValidIn;
  logic                  cmdReadyOut;
  logic [ADDR_WIDTH-1:0] cmdAddrIn;
  logic [LEN_WIDTH-1:0]  cmdLenIn;
  logic                  memRdEnOut;
  logic [ADDR_WIDTH-1:0] memRdAddrOut;
  logic [DATA_WIDTH-1:0] memRdDataIn;
  logic                  accStartOut;
  logic                  accLastOut;
  logic                  accValidOut;
  logic [DATA_WIDTH-1:0] accDataOut;
  logic                  accValidIn;
  logic [DATA_WIDTH-1:0] accDataIn;
  logic                  rspValidOut;
  logic [DATA_WIDTH-1:0] rspDataOut;
  logic                  rspErrOut;
  logic                  rspReadyIn;
  logic                  busyOut;

  // Sequencer side.
  modport master (
    input  cmdValidIn, cmdAddrIn, cmdLenIn, memRdDataIn, accValidIn, accDataIn, rspReadyIn,
    output cmdReadyOut, memRdEnOut, memRdAddrOut, accStartOut, accLastOut, accValidOut,
           accDataOut, rspValidOut, rspDataOut, rspErrOut, busyOut
  );

  // Control-register / RAM / accumulator side.
  modport slave (
    output cmdValidIn, cmdAddrIn, cmdLenIn, memRdDataIn, accValidIn, accDataIn, rspReadyIn,
    input  cmdReadyOut, memRdEnOut, memRdAddrOut, accStartOut, accLastOut, accValidOut,
           accDataOut, rspValidOut, rspDataOut, rspErrOut, busyOut
  );
endinterface

// File: rtl/fp_accum_sequencer_delay.sv
// Generic fixed-latency delay line; LATENCY register stages, cleared on reset.
module fp_accum_sequencer_delay #(
  parameter int DATA_WIDTH = 3,
  parameter int LATENCY    = 1
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut
);
  logic [LATENCY-1:0][DATA_WIDTH-1:0] pipeQ;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      pipeQ <= '0;
    end else begin
      pipeQ[0] <= dataIn;
      for (int i = 1; i < LATENCY; i++) pipeQ[i] <= pipeQ[i-1];
    end
  end

  assign dataOut = pipeQ[LATENCY-1];
endmodule

// File: rtl/fp_accum_sequencer.sv
// Streams a (base, length) operand vector from the RAM into the accumulator and returns the
// single reduced result (or a timeout error) on a response handshake; one reduction in flight.
module fp_accum_sequencer
  import fp_accel_pkg::*;
#(
  parameter int FRAC_WIDTH  = 24,
  parameter int EXP_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int LEN_WIDTH   = 11,
  parameter int MEM_LATENCY = 1,
  parameter int TIMEOUT     = 1023
) (
  input logic clkIn,
  input logic rstIn,
  fp_accum_sequencer_if.master bus
);
  localparam int DATA_WIDTH = dataWidth(FRAC_WIDTH, EXP_WIDTH);
  localparam int TMO_WIDTH  = $clog2(TIMEOUT + 1);

  seqState_t             stateQ, stateD;
  logic [ADDR_WIDTH-1:0] baseQ;
  logic [LEN_WIDTH-1:0]  lenQ, idxQ;
  logic [TMO_WIDTH-1:0]  tmoCntQ, tmoCntNext;
  logic                  tmoArmedQ;
  logic [DATA_WIDTH-1:0] rspDataQ;
  logic                  rspErrQ;
  logic                  accept, issueLast, lastBeat, tmoRun, tmoHit;
  logic [2:0]            pipeIn, pipeOut;

  assign accept    = (stateQ == IDLE) && bus.cmdValidIn;
  assign issueLast = (stateQ == ISSUE) && (idxQ == lenQ - LEN_WIDTH'(1));

  // {valid, start, last} ride alongside the RAM read so they line up with its data.
  assign pipeIn = {stateQ == ISSUE, (stateQ == ISSUE) && (idxQ == '0), issueLast};

  fp_accum_sequencer_delay #(
    .DATA_WIDTH(3),
    .LATENCY   (MEM_LATENCY)
  ) uFlagDelay (
    .clkIn  (clkIn),
    .rstIn  (rstIn),
    .dataIn (pipeIn),
    .dataOut(pipeOut)
  );

  // The cycle the last operand leaves the delay line counts as the first timeout cycle.
  assign lastBeat   = pipeOut[2] & pipeOut[0];
  assign tmoRun     = (stateQ == WAIT) && (tmoArmedQ || lastBeat);
  assign tmoCntNext = tmoArmedQ ? tmoCntQ + TMO_WIDTH'(1) : TMO_WIDTH'(1);
  assign tmoHit     = tmoRun && (tmoCntNext == TMO_WIDTH'(TIMEOUT));

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (bus.cmdValidIn) stateD = (bus.cmdLenIn == '0) ? RESP : ISSUE;
      ISSUE:   if (issueLast) stateD = WAIT;
      WAIT:    if (bus.accValidIn || tmoHit) stateD = RESP;
      RESP:    if (bus.rspReadyIn) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      baseQ     <= '0;
      lenQ      <= '0;
      idxQ      <= '0;
      tmoCntQ   <= '0;
      tmoArmedQ <= 1'b0;
      rspDataQ  <= '0;
      rspErrQ   <= 1'b0;
    end else begin
      if (accept) begin
        baseQ     <= bus.cmdAddrIn;
        lenQ      <= bus.cmdLenIn;
        idxQ      <= '0;
        tmoCntQ   <= '0;
        tmoArmedQ <= 1'b0;
        rspDataQ  <= DATA_WIDTH'(FP_ZERO);
        rspErrQ   <= 1'b0;
      end
      if (stateQ == ISSUE) idxQ <= idxQ + LEN_WIDTH'(1);
      if (tmoRun) begin
        tmoArmedQ <= 1'b1;
        tmoCntQ   <= tmoCntNext;
      end
      // A real result wins over a timeout expiring on the same cycle.
      if (stateQ == WAIT) begin
        if (bus.accValidIn) begin
          rspDataQ <= bus.accDataIn;
          rspErrQ  <= 1'b0;
        end else if (tmoHit) begin
          rspDataQ <= DATA_WIDTH'(FP_ZERO);
          rspErrQ  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.cmdReadyOut  = (stateQ == IDLE);
    bus.memRdEnOut   = (stateQ == ISSUE);
    bus.memRdAddrOut = (stateQ == ISSUE) ? baseQ + idxQ[ADDR_WIDTH-1:0] : '0;
    bus.accValidOut  = pipeOut[2];
    bus.accStartOut  = pipeOut[2] & pipeOut[1];
    bus.accLastOut   = pipeOut[2] & pipeOut[0];
    bus.accDataOut   = pipeOut[2] ? bus.memRdDataIn : '0;
    bus.rspValidOut  = (stateQ == RESP);
    bus.rspDataOut   = (stateQ == RESP) ? rspDataQ : '0;
    bus.rspErrOut    = (stateQ == RESP) && rspErrQ;
    bus.busyOut      = (stateQ != IDLE);
  end
endmodule

// File: tb/tb_fp_accum_sequencer.sv
// Randomized and directed bench for fp_accum_sequencer against a command-level reference model.
module tb_fp_accum_sequencer;
  localparam int ADDR_WIDTH  = 10;
  localparam int LEN_WIDTH   = 11;
  localparam int DATA_WIDTH  = 32;
  localparam int MEM_LATENCY = 2;
  localparam int TIMEOUT     = 16;
  localparam int RAM_DEPTH   = 1 << ADDR_WIDTH;

  logic clkIn = 1'b0;
  logic rstIn = 1'b1;
  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatch = 0;

  logic [DATA_WIDTH-1:0] ramMem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rdPipe [MEM_LATENCY];

  fp_accum_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fp_accum_sequencer #(
    .FRAC_WIDTH(24), .EXP_WIDTH(8), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .MEM_LATENCY(MEM_LATENCY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clkIn(clkIn),
    .rstIn(rstIn),
    .bus  (bus)
  );

  always #5 clkIn = ~clkIn;
  always @(posedge clkIn) cyc <= cyc + 1;

  // Operand RAM with MEM_LATENCY cycles of read latency.
  always @(posedge clkIn) begin
    rdPipe[0] <= ramMem[bus.memRdAddrOut];
    for (int k = 1; k < MEM_LATENCY; k++) rdPipe[k] <= rdPipe[k-1];
  end
  assign bus.memRdDataIn = rdPipe[MEM_LATENCY-1];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Everything except cmdReadyOut, and both data outputs.
  function automatic logic [63:0] ctlOuts();
    return 64'({bus.memRdEnOut, bus.memRdAddrOut, bus.accStartOut, bus.accLastOut,
                bus.accValidOut, bus.rspValidOut, bus.rspErrOut, bus.busyOut});
  endfunction
  function automatic logic [63:0] dataOuts();
    return {bus.accDataOut, bus.rspDataOut};
  endfunction

  // One full command: issue, observe the operand stream, answer (or not), drain the response.
  task automatic runCmd(input int addr, input int len, input bit respond, input int accDelay,
                        input logic [31:0] accResult, input int hold,
                        input bit presentNext, input int nextAddr, input int nextLen);
    int acceptCyc, lastBeatCyc, accCyc, rspCyc, budget, n;
    int addrSeen[$], addrCyc[$], beatCyc[$];
    logic [33:0] beatSeen[$];
    bit accDone;
    logic [31:0] expData;
    logic expErr;
    int expAddr;

    bus.cmdValidIn = 1'b1;
    bus.cmdAddrIn  = ADDR_WIDTH'(addr);
    bus.cmdLenIn   = LEN_WIDTH'(len);
    budget = 0;
    while (!bus.cmdReadyOut && budget < 50) begin
      @(negedge clkIn);
      budget++;
    end
    checkVal("cmd_ready", 64'(bus.cmdReadyOut), 64'd1);
    acceptCyc = cyc;
    @(negedge clkIn);
    bus.cmdValidIn = 1'b0;

    lastBeatCyc = -1000; accCyc = -1000; rspCyc = -1; accDone = 1'b0; budget = 0;
    while (budget < 2000) begin
      if (bus.accValidIn) bus.accValidIn = 1'b0;
      if (bus.memRdEnOut) begin
        addrSeen.push_back(int'(bus.memRdAddrOut));
        addrCyc.push_back(cyc);
      end
      if (bus.accValidOut) begin
        beatSeen.push_back({bus.accDataOut, bus.accStartOut, bus.accLastOut});
        beatCyc.push_back(cyc);
        if (bus.accLastOut) lastBeatCyc = cyc;
      end
      if (bus.rspValidOut) begin
        rspCyc = cyc;
        break;
      end
      if (respond && !accDone && lastBeatCyc >= 0 && cyc == lastBeatCyc + accDelay) begin
        bus.accValidIn = 1'b1;
        bus.accDataIn  = accResult;
        accCyc  = cyc;
        accDone = 1'b1;
      end
      @(negedge clkIn);
      budget++;
    end
    checkVal("rsp_within_budget", 64'(rspCyc >= 0), 64'd1);

    if (len == 0) begin
      expData = 32'h0; expErr = 1'b0;
      checkVal("rsp_delay_len0", 64'(rspCyc - acceptCyc), 64'd1);
    end else if (respond) begin
      expData = accResult; expErr = 1'b0;
      checkVal("rsp_delay_after_acc", 64'(rspCyc - accCyc), 64'd1);
    end else begin
      expData = 32'h0; expErr = 1'b1;
      checkVal("rsp_delay_timeout", 64'(rspCyc - lastBeatCyc), 64'(TIMEOUT));
    end
    checkVal("rsp_data", 64'(bus.rspDataOut), 64'(expData));
    checkVal("rsp_err", 64'(bus.rspErrOut), 64'(expErr));

    checkVal("read_count", 64'(addrSeen.size()), 64'(len));
    checkVal("beat_count", 64'(beatSeen.size()), 64'(len));
    n = (len < addrSeen.size()) ? len : addrSeen.size();
    for (int i = 0; i < n; i++) begin
      expAddr = (addr + i) % RAM_DEPTH;
      checkVal("read_addr", 64'(addrSeen[i]), 64'(expAddr));
      checkVal("read_cycle", 64'(addrCyc[i] - acceptCyc), 64'(i + 1));
    end
    n = (len < beatSeen.size()) ? len : beatSeen.size();
    for (int i = 0; i < n; i++) begin
      expAddr = (addr + i) % RAM_DEPTH;
      checkVal("beat", 64'(beatSeen[i]), 64'({ramMem[expAddr], i == 0, i == len - 1}));
      checkVal("beat_latency", 64'(beatCyc[i] - (acceptCyc + 1 + i)), 64'(MEM_LATENCY));
    end

    if (presentNext) begin
      bus.cmdValidIn = 1'b1;
      bus.cmdAddrIn  = ADDR_WIDTH'(nextAddr);
      bus.cmdLenIn   = LEN_WIDTH'(nextLen);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clkIn);
      checkVal("hold_valid", 64'(bus.rspValidOut), 64'd1);
      checkVal("hold_data", 64'({bus.rspErrOut, bus.rspDataOut}), 64'({expErr, expData}));
      checkVal("hold_cmd_ready", 64'(bus.cmdReadyOut), 64'd0);
    end
    bus.rspReadyIn = 1'b1;
    checkVal("release_cmd_ready", 64'(bus.cmdReadyOut), 64'd0);
    @(negedge clkIn);
    bus.rspReadyIn = 1'b0;
    checkVal("idle_rsp_valid", 64'(bus.rspValidOut), 64'd0);
    checkVal("idle_ready_busy", 64'({bus.cmdReadyOut, bus.busyOut}), 64'b10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seenIssue, budget;
    bus.cmdValidIn = 1'b0;
    bus.cmdAddrIn  = '0;
    bus.cmdLenIn   = '0;
    bus.accValidIn = 1'b0;
    bus.accDataIn  = '0;
    bus.rspReadyIn = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) ramMem[i] = $urandom;
    for (int i = 0; i < 4; i++) ramMem[i] = 32'h3F800000;
    ramMem[1023] = 32'h40400000;

    repeat (3) @(negedge clkIn);
    checkVal("reset_ready", 64'(bus.cmdReadyOut), 64'd1);
    checkVal("reset_ctl", ctlOuts(), 64'd0);
    checkVal("reset_data", dataOuts(), 64'd0);
    rstIn = 1'b0;
    @(negedge clkIn);

    // Four 1.0 operands summed to 4.0.
    runCmd(0, 4, 1'b1, 2, 32'h40800000, 0, 1'b0, 0, 0);
    // Empty vector.
    runCmd(5, 0, 1'b1, 0, 32'hDEADBEEF, 0, 1'b0, 0, 0);
    // Single element at the top address; then a vector wrapping past address 0.
    runCmd(1023, 1, 1'b1, 0, 32'h40400000, 0, 1'b0, 0, 0);
    runCmd(1022, 3, 1'b1, 1, 32'h3F000000, 0, 1'b0, 0, 0);
    // No result: timeout, then a stray result while idle must be ignored.
    runCmd(40, 3, 1'b0, 0, 32'h0, 0, 1'b0, 0, 0);
    bus.accValidIn = 1'b1;
    bus.accDataIn  = 32'h12345678;
    @(negedge clkIn);
    bus.accValidIn = 1'b0;
    checkVal("late_result_ignored", 64'({bus.rspValidOut, bus.busyOut}), 64'd0);
    @(negedge clkIn);
    checkVal("late_result_ignored2", 64'({bus.rspValidOut, bus.busyOut}), 64'd0);
    // Response backpressure with a second command waiting.
    runCmd(8, 5, 1'b1, 3, 32'hC1200000, 10, 1'b1, 200, 2);
    runCmd(200, 2, 1'b1, 4, 32'h41000000, 0, 1'b0, 0, 0);

    // Reset while issuing element 2 of 8.
    bus.cmdValidIn = 1'b1;
    bus.cmdAddrIn  = 10'd100;
    bus.cmdLenIn   = 11'd8;
    @(negedge clkIn);
    bus.cmdValidIn = 1'b0;
    seenIssue = 0;
    budget = 0;
    while (budget < 20) begin
      if (bus.memRdEnOut) seenIssue++;
      if (seenIssue == 3) break;
      @(negedge clkIn);
      budget++;
    end
    checkVal("abort_point_addr", 64'(bus.memRdAddrOut), 64'd102);
    rstIn = 1'b1;
    #1;
    checkVal("abort_ready", 64'(bus.cmdReadyOut), 64'd1);
    checkVal("abort_ctl", ctlOuts(), 64'd0);
    checkVal("abort_data", dataOuts(), 64'd0);
    @(negedge clkIn);
    rstIn = 1'b0;
    @(negedge clkIn);
    checkVal("after_abort_ready_busy", 64'({bus.cmdReadyOut, bus.busyOut}), 64'b10);
    runCmd(300, 2, 1'b1, 1, 32'h40A00000, 0, 1'b0, 0, 0);

    // Randomized commands.
    for (int t = 0; t < 24; t++) begin
      int a, l, d, hd;
      bit resp, nxt;
      logic [31:0] res;
      a    = $urandom_range(0, RAM_DEPTH - 1);
      l    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 24);
      resp = ($urandom_range(0, 4) != 0);
      d    = $urandom_range(0, 10);
      res  = $urandom;
      hd   = $urandom_range(0, 3);
      nxt  = 1'b0;
      runCmd(a, l, resp, d, res, hd, nxt, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
